seq_multiplier_digit: RTL

//   Parametrised digit-serial multiplier: controller plus datapath in one block.

---
 rtl/seq_multiplier_digit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_multiplier_digit.sv
// Digit-serial WIDTH x WIDTH multiplier (unsigned or two's complement), one DIGIT x DIGIT partial product per cycle.
// Product and done appear K*K+1 edges after the accepted start; a start during CALC, FINISH or DONE aborts to ERR.
module seq_multiplier_digit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               reset_a_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] product,
  output logic [2:0]         state_out
);

  localparam int K   = WIDTH / DIGIT;
  localparam int NPP = K * K;
  localparam int CW  = (NPP > 1) ? $clog2(NPP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NPP - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    CALC   = 3'b001,
    FINISH = 3'b010,
    DONE   = 3'b100,
    ERR    = 3'b101
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, prod_q, prod_d;

  logic                 capture;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [CW-1:0]        ii, jj;
  logic [DIGIT-1:0]     a_dig, b_dig;
  logic [2*DIGIT-1:0]   pp;
  logic [2*WIDTH-1:0]   pp_sh;

  // Signed operands are reduced to magnitudes; -2^(W-1) wraps onto itself, which is 2^(W-1) unsigned.
  always_comb begin
    a_abs = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_abs = (signed_mode && b[WIDTH-1]) ? -b : b;
    ii    = count_q % CW'(K);
    jj    = count_q / CW'(K);
    a_dig = DIGIT'(a_mag_q >> (int'(ii) * DIGIT));
    b_dig = DIGIT'(b_mag_q >> (int'(jj) * DIGIT));
    pp    = (2*DIGIT)'(a_dig) * (2*DIGIT)'(b_dig);
    pp_sh = (2*WIDTH)'(pp) << ((int'(ii) + int'(jj)) * DIGIT);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    capture = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          capture = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (start) begin
          state_d = ERR;
        end else begin
          acc_d = acc_q + pp_sh;
          if (count_q == LAST) state_d = FINISH;
          else                 count_d = count_q + CW'(1);
        end
      end
      FINISH: begin
        if (start) begin
          state_d = ERR;
        end else begin
          prod_d  = neg_q ? -acc_q : acc_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = start ? ERR : IDLE;
      default: state_d = IDLE;
    endcase
    if (capture) begin
      a_mag_d = a_abs;
      b_mag_d = b_abs;
      neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      state_q <= IDLE;
      count_q <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign busy      = (state_q == CALC) || (state_q == FINISH);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign product   = prod_q;
  assign state_out = state_q;

endmodule
